// File: rtl/mul_arbiter_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
package mul_arbiter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t RESP = 2'd2;

    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Request/response bundle between two requesters and the shared multiplier arbiter.
interface mul_arbiter_if #(
    parameter int DATA_WIDTH = mul_arbiter_pkg::DEFAULT_DATA_WIDTH
);

    logic [1:0]                   req_valid;
    logic [1:0]                   req_ready;
    logic [DATA_WIDTH-1:0]        a0;
    logic [DATA_WIDTH-1:0]        b0;
    logic [DATA_WIDTH-1:0]        a1;
    logic [DATA_WIDTH-1:0]        b1;
    logic [1:0]                   rsp_valid;
    logic [1:0]                   rsp_ready;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic                         busy;

    modport master (
        output req_valid, a0, b0, a1, b1, rsp_ready,
        input  req_ready, rsp_valid, product, busy
    );

    modport slave (
        input  req_valid, a0, b0, a1, b1, rsp_ready,
        output req_ready, rsp_valid, product, busy
    );

endinterface

// File: rtl/mul_arbiter_booth_mul.sv
// Purely combinational radix-2 Booth multiplier, two's-complement signed, full-width result.
module booth_mul_combinational #(
    parameter int DATA_WIDTH = mul_arbiter_pkg::DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]          a,
    input  logic [DATA_WIDTH-1:0]          b,
    output logic signed [2*DATA_WIDTH-1:0] product
);

    logic signed [2*DATA_WIDTH-1:0] a_ext;
    logic signed [2*DATA_WIDTH-1:0] acc;
    logic                           prev;

    // Sign-extending a to 2*W keeps -a representable even for the most-negative operand.
    always_comb begin
        a_ext = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
        acc   = '0;
        prev  = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            case ({b[i], prev})
                2'b01:   acc = acc + (a_ext <<< i);
                2'b10:   acc = acc - (a_ext <<< i);
                default: acc = acc;
            endcase
            prev = b[i];
        end
        product = acc;
    end

endmodule

// File: rtl/mul_arbiter.sv
// Arbitrates two requesters onto one registered Booth multiplier (IDLE -> CALC -> RESP).
// Define MUL_ARB_RR_EN for round-robin ties; default build is fixed priority to requester 0.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic         clk,
    input  logic         clr,
    mul_arbiter_if.slave bus
);

    state_t                         state;
    logic                           owner;
    logic [DATA_WIDTH-1:0]          op_a;
    logic [DATA_WIDTH-1:0]          op_b;
    logic signed [2*DATA_WIDTH-1:0] product_q;
    logic signed [2*DATA_WIDTH-1:0] mul_out;
    logic                           grant_any;
    logic                           grant_idx;
    logic                           accept;

`ifdef MUL_ARB_RR_EN
    logic rr_ptr;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rr_ptr <= REQ0;
        end else if (accept) begin
            rr_ptr <= ~grant_idx;
        end
    end

    always_comb begin
        grant_any = |bus.req_valid;
        grant_idx = REQ0;
        if (&bus.req_valid) begin
            grant_idx = rr_ptr;
        end else if (bus.req_valid[1]) begin
            grant_idx = REQ1;
        end
    end
`else
    always_comb begin
        grant_any = |bus.req_valid;
        grant_idx = REQ0;
        if (!bus.req_valid[0] && bus.req_valid[1]) begin
            grant_idx = REQ1;
        end
    end
`endif

    // Gating with clr keeps req_ready low for the whole reset pulse, not just after the state flop clears.
    assign accept        = (state == IDLE) && grant_any && clr;
    assign bus.req_ready = accept ? req_onehot(grant_idx) : 2'b00;
    assign bus.rsp_valid = (state == RESP) ? req_onehot(owner) : 2'b00;
    assign bus.busy      = (state != IDLE);
    assign bus.product   = product_q;

    booth_mul_combinational #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mul (
        .a       (op_a),
        .b       (op_b),
        .product (mul_out)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            owner     <= REQ0;
            op_a      <= '0;
            op_b      <= '0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= grant_idx;
                        op_a  <= grant_idx ? bus.a1 : bus.a0;
                        op_b  <= grant_idx ? bus.b1 : bus.b0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    product_q <= mul_out;
                    state     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready[owner]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: vector table plus hand sequences, scoreboard queue of expected products.
module tb_mul_arbiter;
    import mul_arbiter_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic           owner;
        logic [2*W-1:0] product;
    } exp_t;

    typedef struct {
        logic [1:0]   valid;
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        logic [1:0]   grant;
    } vec_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    mul_arbiter_if #(.DATA_WIDTH(W)) bus();

    mul_arbiter #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
    endfunction

    // Present one request, check the grant, push the expected result, then confirm the CALC cycle.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(negedge clk);
        bus.req_valid = v.valid;
        bus.a0 = v.a0;
        bus.b0 = v.b0;
        bus.a1 = v.a1;
        bus.b1 = v.b1;
        #1;
        chk("req_ready", 64'(bus.req_ready), 64'(v.grant));
        if (v.grant != 2'b00) begin
            e.owner   = v.grant[1];
            e.product = v.grant[1] ? model(v.a1, v.b1) : model(v.a0, v.b0);
            sbq.push_back(e);
        end
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk("calc_busy", 64'(bus.busy), 64'd1);
        chk("calc_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("calc_req_ready", 64'(bus.req_ready), 64'd0);
    endtask

    // Wait for the response, hold it for holdCycles with holdReady/holdValid driven, then release.
    task automatic checkOutput(input int holdCycles, input logic [1:0] holdReady, input logic [1:0] holdValid);
        int   waited;
        exp_t e;
        waited = 0;
        while (bus.rsp_valid == 2'b00 && waited < 6) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("rsp_latency", 64'(waited), 64'd1);
        chk("sb_size", 64'(sbq.size()), 64'd1);
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(req_onehot(e.owner)));
        chk("product", 64'(bus.product), e.product);
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            bus.rsp_ready = holdReady;
            bus.req_valid = holdValid;
            bus.a0 = $urandom;
            bus.a1 = $urandom;
            #1;
            chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'(req_onehot(e.owner)));
            chk("hold_product", 64'(bus.product), e.product);
            chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
            chk("hold_busy", 64'(bus.busy), 64'd1);
        end
        @(negedge clk);
        bus.rsp_ready = req_onehot(e.owner);
        @(negedge clk);
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b00;
        #1;
        chk("idle_busy", 64'(bus.busy), 64'd0);
        chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("idle_product_hold", 64'(bus.product), e.product);
    endtask

    task automatic runTxn(input vec_t v);
        applyStimulus(v);
        checkOutput(0, 2'b00, 2'b00);
    endtask

    initial begin
        vec_t v;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b00;
        bus.a0 = '0;
        bus.b0 = '0;
        bus.a1 = '0;
        bus.b1 = '0;

        vecs[0] = '{2'b01, 32'd7,          32'hFFFF_FFFD, 32'd0,          32'd0,          2'b01};
        vecs[1] = '{2'b10, 32'd0,          32'd0,         32'h8000_0000,  32'h8000_0000,  2'b10};
        vecs[2] = '{2'b01, 32'hFFFF_FFFF,  32'h7FFF_FFFF, 32'd0,          32'd0,          2'b01};
        vecs[3] = '{2'b10, 32'd0,          32'd0,         32'd12345,      32'hFFFF_FD4A,  2'b10};
        vecs[4] = '{2'b01, 32'd0,          32'hDEAD_BEEF, 32'd5,          32'd5,          2'b01};
        vecs[5] = '{2'b10, 32'd1,          32'd1,         32'h7FFF_FFFF,  32'h7FFF_FFFF,  2'b10};
        vecs[6] = '{2'b01, 32'h8000_0000,  32'd1,         32'd0,          32'd0,          2'b01};
        vecs[7] = '{2'b10, 32'd3,          32'd3,         32'h8000_0000,  32'h7FFF_FFFF,  2'b10};

        #2;
        chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_product", 64'(bus.product), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        bus.req_valid = 2'b00;
        @(negedge clk);
        clr = 1'b1;

        chk("ref_most_negative", model(32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);

        for (int i = 0; i < 8; i++) begin
            runTxn(vecs[i]);
        end

        for (int i = 0; i < 6; i++) begin
            v.valid = 2'($urandom_range(1, 2));
            v.a0    = $urandom;
            v.b0    = $urandom;
            v.a1    = $urandom;
            v.b1    = $urandom;
            v.grant = v.valid;
            runTxn(v);
        end

        $display("[TB] long hold in RESP with new requests pending");
        v = '{2'b01, 32'd9, 32'hFFFF_FFF7, 32'd0, 32'd0, 2'b01};
        applyStimulus(v);
        checkOutput(10, 2'b00, 2'b11);

        $display("[TB] non-owner rsp_ready ignored");
        v = '{2'b01, 32'd3, 32'd4, 32'd0, 32'd0, 2'b01};
        applyStimulus(v);
        checkOutput(3, 2'b10, 2'b00);

        $display("[TB] clr pulse during CALC");
        @(negedge clk);
        bus.req_valid = 2'b01;
        bus.a0 = 32'd5;
        bus.b0 = 32'd6;
        #1;
        chk("abort_req_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        #1;
        chk("abort_calc_busy", 64'(bus.busy), 64'd1);
        clr = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_product", 64'(bus.product), 64'd0);
        chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("abort_req_ready_gated", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        bus.req_valid = 2'b00;
        clr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("post_abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            chk("post_abort_busy", 64'(bus.busy), 64'd0);
        end
        chk("post_abort_product", 64'(bus.product), 64'd0);

        $display("[TB] both requesters valid");
        v = '{2'b11, 32'd2, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 2'b01};
        runTxn(v);
`ifdef MUL_ARB_RR_EN
        v.grant = 2'b10;
        runTxn(v);
        v.grant = 2'b01;
        runTxn(v);
`else
        runTxn(v);
        runTxn(v);
`endif
        v = '{2'b01, 32'd11, 32'd13, 32'd0, 32'd0, 2'b01};
        runTxn(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand width of the shared multiplier.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 clr  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid[1:0]  input  2  requester n presents operands.
REQ-005 req_ready[1:0]  output  2  arbiter accepts requester n this cycle.
REQ-006 a0, b0 / a1, b1  input  DATA_WIDTH each  multiplicand / multiplier of requester 0 / 1.
REQ-007 rsp_valid[1:0]  output  2  product valid for requester n.
REQ-008 rsp_ready[1:0]  input  2  requester n takes product.
REQ-009 product  output  2*DATA_WIDTH  signed product, shared by both responders.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 FSM states IDLE, CALC, RESP; encoding free.
REQ-012 IDLE: req_ready[n] high only for granted requester n, and only if req_valid[n]; at most one req_ready bit high.
REQ-013 Accept on req_valid[n] & req_ready[n]: latch operands, record owner n, go to CALC.
REQ-014 CALC lasts exactly one cycle: register the multiplier output into product, go to RESP.
REQ-015 RESP: rsp_valid[owner] high, other bit low; hold product stable until rsp_ready[owner]; then go to IDLE.
REQ-016 Latency: accept at edge N; rsp_valid high from cycle N+2; back-to-back throughput one op per 3 cycles minimum.
REQ-017 rsp_ready of non-owner ignored; req_valid ignored outside IDLE (req_ready all low).
REQ-018 Arithmetic: two's-complement signed, full 2*DATA_WIDTH result, no truncation; most-negative x most-negative exact.
REQ-019 Grant policy when both valid in IDLE: per REQ-023/024; single valid requester always granted.
REQ-020 product holds last value in IDLE; rsp_valid low in IDLE and CALC.

Reset
REQ-021 clr low at any time (incl. CALC/RESP): state IDLE, req_ready=0, rsp_valid=0, product=0, busy=0, round-robin pointer favours requester 0; in-flight op discarded, no response.
REQ-022 Outputs valid combinationally from reset state; first grant possible first cycle after clr deasserts.

Configuration
REQ-023 MUL_ARB_RR_EN defined: round-robin; pointer moves to the other requester after each accept; ties go to pointer.
REQ-024 MUL_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties; no pointer register.

Structure
REQ-025 Shared package: FSM state typedef, requester index constants (REQ0=0, REQ1=1), default DATA_WIDTH.
REQ-026 One sub-module: booth_mul_combinational instance, DATA_WIDTH passed through, fed from operand registers.
REQ-027 Operand mux, arbitration and FSM in mul_arbiter; no other sub-modules.

Verification
REQ-028 Req0 only, a0=7, b0=-3 -> accepted, rsp_valid=2'b01 two cycles later, product=-21, held until rsp_ready[0].
REQ-029 Both valid, RR build: first a0=2,b0=3 -> 6 to req0; next a1=-4,b1=-5 -> 20 to req1; fixed build: req0 served twice while held valid.
REQ-030 a=0x80000000, b=0x80000000 -> product=0x4000000000000000; a=-1, b=0x7FFFFFFF -> 0xFFFFFFFF80000001.
REQ-031 rsp_ready held low 10 cycles in RESP -> product stable, req_ready=0, new req_valid ignored; release -> IDLE next cycle.
REQ-032 clr pulsed low during CALC -> all outputs 0 immediately, no rsp_valid after release, next request served normally.
REQ-033 rsp_ready[1] asserted while owner=0 -> no state change, rsp_valid stays 2'b01.
